// File: rtl/plantard_batch_ctrl.sv
// Streams a block of coefficients from RAM through the Plantard reducer and
// writes the reduced values back to a destination region of the same RAM.
module plantard_batch_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 10,
  parameter int MM_LAT     = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_mm_a,
  input  logic [DATA_WIDTH-1:0] i_mm_c,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data
);
  localparam int DL = RD_LAT + MM_LAT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t                         r_state, w_next;
  logic [LEN_WIDTH-1:0]           r_len, r_issue_cnt;
  logic [ADDR_WIDTH-1:0]          r_src, r_dst;
  logic [DL-1:0]                  r_vld_pipe;
  logic [DL-1:0][ADDR_WIDTH-1:0]  r_idx_pipe;

  logic w_rd, w_abort, w_last_issue, w_last_wr;

  assign w_abort      = i_abort && (r_state == S_ISSUE || r_state == S_DRAIN);
  assign w_rd         = (r_state == S_ISSUE) && !i_abort;
  assign w_last_issue = (r_issue_cnt == r_len - 1'b1);
  assign w_last_wr    = r_vld_pipe[DL-1] &&
                        (LEN_WIDTH'(r_idx_pipe[DL-1]) == r_len - 1'b1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_len == '0) ? S_FIN : S_ISSUE;
      S_ISSUE: if (i_abort) w_next = S_IDLE;
               else if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (i_abort) w_next = S_IDLE;
               else if (w_last_wr) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_issue_cnt <= '0;
      r_vld_pipe  <= '0;
      r_idx_pipe  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_len       <= i_len;
        r_src       <= i_src_base;
        r_dst       <= i_dst_base;
        r_issue_cnt <= '0;
      end else if (w_rd) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
      end
      // The delay line covers RAM read plus reducer latency; abort flushes it.
      if (w_abort) r_vld_pipe <= '0;
      else         r_vld_pipe <= {r_vld_pipe[DL-2:0], w_rd};
      r_idx_pipe <= {r_idx_pipe[DL-2:0], ADDR_WIDTH'(r_issue_cnt)};
    end
  end

  assign o_busy    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign o_done    = (r_state == S_FIN);
  assign o_rd_en   = w_rd;
  assign o_rd_addr = r_src + ADDR_WIDTH'(r_issue_cnt);
  assign o_mm_a    = i_rd_data;
  assign o_wr_en   = r_vld_pipe[DL-1];
  assign o_wr_addr = r_dst + r_idx_pipe[DL-1];
  assign o_wr_data = i_mm_c;
endmodule
